// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path.
//  - SEG_CODES : active-low {g..a} patterns for hex 0..F, indexed by value
//  - SEG_BLANK : all segments off
//  - seg7_state_e : capture FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index i holds the pattern that displays hex digit i.
  // 9 and A are drawn without segment d; 7 is drawn with segment a lit.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_WAITCHG = 2'd3
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_lut.sv
// Combinational classifier: 7-bit active-low segment pattern -> hex value.
// Ports:
//  pattern  in   7  segment pattern, bit0=a .. bit6=g, active-low
//  hit      out  1  pattern is one of the 16 legal digit codes
//  blank    out  1  pattern is all segments off
//  hex      out  4  decoded digit (0 when hit=0)
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic       blank,
  output logic [3:0] hex
);

  // Legal codes are all distinct, so at most one iteration can match.
  always_comb begin
    hit = 1'b0;
    hex = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODES[i]) begin
        hit = 1'b1;
        hex = 4'(i);
      end
    end
    blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_capture_encoder.sv
// Samples an active-low 7-segment bus, waits for it to be stable and emits
// the decoded value once per stable pattern.
// Handshake: out_valid rises with a frozen result; the result transfers on a
// rising clk edge where out_valid=1 and out_ready=1. out_valid never drops
// before that transfer except by reset.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  seg_in[6:0]    segment bus (may be asynchronous to clk)
//  sample_en      capture enable
//  out_ready      consumer ready
//  out_valid      result available
//  out_hex[3:0]   decoded value (0 when blank or error)
//  out_blank      pattern was all segments off
//  out_err        pattern was not a legal code and not blank
//  busy           FSM not idle
//  state_dbg[1:0] current FSM state (seg7_state_e encoding)
module seg7_capture_encoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_hex,
  output logic       out_blank,
  output logic       out_err,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // A single matching sample is already "stable": restart paths emit at once.
  localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

  logic [6:0]  sync1_q, s;
  logic [6:0]  ref_q;
  logic [6:0]  last_q;
  logic        have_last_q;
  logic [CW-1:0] cnt_q, cnt_nxt;
  seg7_state_e state_q;

  logic        lut_hit, lut_blank;
  logic [3:0]  lut_hex;

  logic        start_trk, to_idle, reach, emit, hold_done;

  assign state_dbg = state_q;

  // Two-flop synchroniser; resets to the blank pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SEG_BLANK;
      s       <= SEG_BLANK;
    end else begin
      sync1_q <= seg_in;
      s       <= sync1_q;
    end
  end

  seg7_pattern_lut u_lut (
    .pattern (s),
    .hit     (lut_hit),
    .blank   (lut_blank),
    .hex     (lut_hex)
  );

  // Saturating stability count; a differing sample restarts it at 1.
  always_comb begin
    cnt_nxt = CNT_ONE;
    if (s == ref_q) begin
      cnt_nxt = (cnt_q >= STABLE_C) ? cnt_q : cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    start_trk = 1'b0;
    to_idle   = 1'b0;
    reach     = 1'b0;
    hold_done = 1'b0;
    case (state_q)
      ST_IDLE:    start_trk = sample_en;
      ST_TRACK: begin
        to_idle = !sample_en;
        reach   = sample_en && (cnt_nxt >= STABLE_C);
      end
      ST_HOLD: begin
        to_idle   = out_ready && !sample_en;
        start_trk = out_ready && sample_en && (s != last_q);
        hold_done = out_ready && sample_en && (s == last_q);
      end
      ST_WAITCHG: begin
        to_idle   = !sample_en;
        start_trk = sample_en && (s != last_q);
      end
      default: ;
    endcase
    // A pattern that settles back to the one just emitted (short glitch
    // away and back) is not reported a second time.
    emit = (start_trk && ONE_SHOT) ||
           (reach && !(have_last_q && (s == last_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ref_q       <= SEG_BLANK;
      cnt_q       <= '0;
      last_q      <= SEG_BLANK;
      have_last_q <= 1'b0;
      out_valid   <= 1'b0;
      out_hex     <= 4'h0;
      out_blank   <= 1'b0;
      out_err     <= 1'b0;
      busy        <= 1'b0;
    end else if (emit) begin
      state_q     <= ST_HOLD;
      ref_q       <= s;
      cnt_q       <= cnt_nxt;
      last_q      <= s;
      have_last_q <= 1'b1;
      out_valid   <= 1'b1;
      out_hex     <= lut_hit ? lut_hex : 4'h0;
      out_blank   <= lut_blank;
      out_err     <= !lut_hit && !lut_blank;
      busy        <= 1'b1;
    end else if (to_idle) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      have_last_q <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else if (start_trk) begin
      state_q   <= ST_TRACK;
      ref_q     <= s;
      cnt_q     <= CNT_ONE;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else if (reach || hold_done) begin
      state_q   <= ST_WAITCHG;
      ref_q     <= s;
      cnt_q     <= cnt_nxt;
      out_valid <= 1'b0;
    end else if (state_q == ST_TRACK) begin
      ref_q <= s;
      cnt_q <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_capture_encoder.sv
module tb_seg7_capture_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic       sample_en = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_blank, out_err, busy;
  logic [3:0] out_hex;
  logic [1:0] state_dbg;

  logic [6:0] seg_in1 = 7'h7F;
  logic       sample_en1 = 1'b0;
  logic       out_ready1 = 1'b1;
  logic       out_valid1, out_blank1, out_err1, busy1;
  logic [3:0] out_hex1;
  logic [1:0] state_dbg1;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results as {hex, blank, err}.
  logic [5:0] exp_q[$];

  // Hand-written code table, hex 0..F.
  logic [6:0] codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seg7_capture_encoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .sample_en (sample_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_hex   (out_hex),
    .out_blank (out_blank),
    .out_err   (out_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  seg7_capture_encoder #(.STABLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in1),
    .sample_en (sample_en1),
    .out_ready (out_ready1),
    .out_valid (out_valid1),
    .out_hex   (out_hex1),
    .out_blank (out_blank1),
    .out_err   (out_err1),
    .busy      (busy1),
    .state_dbg (state_dbg1)
  );

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step 1ns past the edge for driving/sampling.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count rising edges until out_valid is seen (sampled on the falling edge).
  task automatic wait_valid0(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) return;
    end
    n = 99;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got hex=0x%0h blank=%0b err=%0b, expected none",
                 out_hex, out_blank, out_err);
      end else begin
        check("result", {out_hex, out_blank, out_err}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    #1 rst_n = 1'b0;
    tick(2);
    check("rst_valid", out_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_hex",   out_hex, 0);
    check("rst_blank", out_blank, 0);
    check("rst_err",   out_err, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Enabling on the idle blank bus reports blank first.
    exp_q.push_back({4'h0, 1'b1, 1'b0});
    sample_en  = 1'b1;
    sample_en1 = 1'b1;
    wait_drain("init_blank");
    tick(4);

    // 1: sweep all legal codes, latency 6 clocks each.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({4'(i), 1'b0, 1'b0});
      seg_in = codes[i];
      wait_valid0(n);
      check($sformatf("sweep_latency_%0d", i), n, 6);
      tick(4);
    end
    wait_drain("sweep_drain");

    // 2: blank, illegal, digit 4.
    exp_q.push_back({4'h0, 1'b1, 1'b0});
    seg_in = 7'h7F;
    tick(10);
    exp_q.push_back({4'h0, 1'b0, 1'b1});
    seg_in = 7'h7E;
    tick(10);
    exp_q.push_back({4'h4, 1'b0, 1'b0});
    seg_in = 7'h19;
    tick(10);
    wait_drain("t2_drain");

    // 3: short glitch while "1" is held must not re-emit.
    exp_q.push_back({4'h1, 1'b0, 1'b0});
    seg_in = 7'h79;
    tick(10);
    seg_in = 7'h24;
    tick(3);
    seg_in = 7'h79;
    tick(15);
    check("t3_no_repeat", exp_q.size(), 0);
    check("t3_valid_low", out_valid, 0);
    check("t3_busy", busy, 1);

    // 4: back-pressure while the bus changes 3 -> 5.
    out_ready = 1'b0;
    exp_q.push_back({4'h3, 1'b0, 1'b0});
    seg_in = 7'h30;
    tick(8);
    check("t4_valid_a", out_valid, 1);
    check("t4_hex_a", out_hex, 3);
    exp_q.push_back({4'h5, 1'b0, 1'b0});
    seg_in = 7'h12;
    tick(12);
    check("t4_valid_b", out_valid, 1);
    check("t4_hex_b", out_hex, 3);
    out_ready = 1'b1;
    wait_drain("t4_drain");
    tick(3);

    // 5a: sample_en dropped during HOLD; handshake still completes.
    out_ready = 1'b0;
    exp_q.push_back({4'h0, 1'b0, 1'b0});
    seg_in = 7'h40;
    wait_valid0(n);
    check("t5_latency", n, 6);
    tick(1);
    sample_en = 1'b0;
    tick(3);
    check("t5_hold_valid", out_valid, 1);
    check("t5_hold_busy", busy, 1);
    out_ready = 1'b1;
    tick(1);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_valid", out_valid, 0);
    check("t5_popped", exp_q.size(), 0);

    // 5b: reset pulse mid-HOLD discards the pending result.
    out_ready = 1'b0;
    sample_en = 1'b1;
    tick(8);
    check("t5_pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    sample_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(10);
    check("t5_quiet", out_valid, 0);

    // 6: STABLE_CYCLES=1 instance, step to 8 gives result 3 clocks later.
    seg_in1 = 7'h00;
    n = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid1) begin
        n = k;
        break;
      end
    end
    check("t6_latency", n, 3);
    check("t6_hex", {out_hex1, out_blank1, out_err1}, {4'h8, 1'b0, 1'b0});

    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
